// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the PC branch sequencer
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        BR_B   = 2'd0,
        BR_CBZ = 2'd1,
        BR_BLT = 2'd2,
        BR_RSV = 2'd3
    } br_kind_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } seq_state_t;

    localparam int FLUSH_CNT_W = 2;

endpackage

// File: rtl/br_cond_eval.sv
// rtl/br_cond_eval.sv - combinational taken decision for B / CBZ / B.LT
module br_cond_eval
    import cpu_ctrl_pkg::*;
(
    input  logic [1:0] br_kind,
    input  logic       rt_zero,
    input  logic       flag_n,
    input  logic       flag_v,
    output logic       taken
);

    br_kind_t w_kind;

    assign w_kind = br_kind_t'(br_kind);

    always_comb begin
        taken = 1'b0;
        case (w_kind)
            BR_B:    taken = 1'b1;
            BR_CBZ:  taken = rt_zero;
            BR_BLT:  taken = flag_n ^ flag_v;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - PC/IF-ID control FSM, flush counter and taken-branch counter
// Optional build macro BR_DELAY_SLOT_EN: taken branches keep the next fetch (no flush).
module branch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic [1:0]       br_kind,
    input  logic             rt_zero,
    input  logic             flag_n,
    input  logic             flag_v,
    input  logic             load_use,
    input  logic             halt_req,
    output logic             BrTaken,
    output logic             UnCondBr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    seq_state_t             r_state;
    seq_state_t             w_next_state;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;
    logic [FLUSH_CNT_W-1:0] w_next_cnt;
    logic [CNT_W-1:0]       r_taken_cnt;
    logic                   w_taken;
    logic                   w_cnt_inc;
    logic                   w_br_taken;
    logic                   w_pc_en;
    logic                   w_ifid_en;
    logic                   w_ifid_flush;

    br_cond_eval u_cond (
        .br_kind (br_kind),
        .rt_zero (rt_zero),
        .flag_n  (flag_n),
        .flag_v  (flag_v),
        .taken   (w_taken)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_RUN;
            r_flush_cnt <= '0;
            r_taken_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_next_cnt;
            if (w_cnt_inc && (r_taken_cnt != {CNT_W{1'b1}})) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_flush_cnt;
        w_cnt_inc    = 1'b0;
        w_br_taken   = 1'b0;
        w_pc_en      = 1'b0;
        w_ifid_en    = 1'b0;
        w_ifid_flush = 1'b0;
        case (r_state)
            S_RUN: begin
                if (halt_req) begin
                    w_next_state = S_HALT;
                end else if (load_use) begin
                    // Branch is held in decode and re-resolved after the bubble.
                    w_next_state = S_STALL;
                end else if (br_valid && w_taken) begin
                    w_br_taken = 1'b1;
                    w_pc_en    = 1'b1;
                    w_cnt_inc  = 1'b1;
`ifdef BR_DELAY_SLOT_EN
                    w_ifid_en  = 1'b1;
`else
                    w_ifid_flush = 1'b1;
                    if (FLUSH_INIT != '0) begin
                        w_next_state = S_FLUSH;
                        w_next_cnt   = FLUSH_INIT;
                    end
`endif
                end else begin
                    w_pc_en   = 1'b1;
                    w_ifid_en = 1'b1;
                end
            end
            S_STALL: begin
                w_next_state = halt_req ? S_HALT : S_RUN;
            end
            S_FLUSH: begin
                w_pc_en      = 1'b1;
                w_ifid_flush = 1'b1;
                if (halt_req) begin
                    w_next_state = S_HALT;
                    w_next_cnt   = '0;
                end else begin
                    // Counter holds the flush cycles still to go, this one included.
                    w_next_cnt = (r_flush_cnt != '0) ? r_flush_cnt - 1'b1 : '0;
                    if (r_flush_cnt <= FLUSH_CNT_W'(1)) begin
                        w_next_state = S_RUN;
                    end
                end
            end
            default: begin
                w_next_state = S_HALT;
            end
        endcase
    end

    assign BrTaken    = reset & w_br_taken;
    assign UnCondBr   = reset & (br_kind == BR_B);
    assign pc_en      = reset & w_pc_en;
    assign ifid_en    = reset & w_ifid_en;
    assign ifid_flush = reset & w_ifid_flush;
    assign state_o    = r_state;
    assign taken_cnt  = r_taken_cnt;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - checks two sequencer configurations against a behavioural model
module tb_branch_sequencer;

`ifdef BR_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       br_valid;
    logic [1:0] br_kind;
    logic       rt_zero, flag_n, flag_v, load_use, halt_req;

    logic [1:0] bt, ub, pc, ie, fl;
    logic [1:0] st0, st1;
    logic [15:0] tc0;
    logic [2:0]  tc1;

    int n_pass  = 0;
    int n_total = 0;

    // Model state per instance: halted, stall pending, flush cycles left, taken count
    int m_halt[2];
    int m_stall[2];
    int m_fl[2];
    int m_cnt[2];
    int fcyc[2] = '{3, 1};
    int cmax[2] = '{65535, 7};

    always #5 clk = ~clk;

    branch_sequencer #(.FLUSH_CYCLES(3), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_kind(br_kind),
        .rt_zero(rt_zero), .flag_n(flag_n), .flag_v(flag_v), .load_use(load_use),
        .halt_req(halt_req), .BrTaken(bt[0]), .UnCondBr(ub[0]), .pc_en(pc[0]),
        .ifid_en(ie[0]), .ifid_flush(fl[0]), .state_o(st0), .taken_cnt(tc0)
    );

    branch_sequencer #(.FLUSH_CYCLES(1), .CNT_W(3)) u1 (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_kind(br_kind),
        .rt_zero(rt_zero), .flag_n(flag_n), .flag_v(flag_v), .load_use(load_use),
        .halt_req(halt_req), .BrTaken(bt[1]), .UnCondBr(ub[1]), .pc_en(pc[1]),
        .ifid_en(ie[1]), .ifid_flush(fl[1]), .state_o(st1), .taken_cnt(tc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Applies one cycle of inputs, checks both instances, then advances the model past the edge.
    task automatic step(input logic rst, input logic v, input logic [1:0] k,
                        input logic z, input logic n, input logic ov,
                        input logic lu, input logic h);
        @(negedge clk);
        reset = rst; br_valid = v; br_kind = k; rt_zero = z;
        flag_n = n; flag_v = ov; load_use = lu; halt_req = h;
        #1;
        for (int i = 0; i < 2; i++) begin
            int e_bt, e_ub, e_pc, e_ie, e_fl, e_st, e_cnt, tk;
            e_bt = 0; e_ub = 0; e_pc = 0; e_ie = 0; e_fl = 0; e_st = 0;
            tk = (k == 2'd0) || (k == 2'd1 && z) || (k == 2'd2 && (n != ov));
            if (!rst) begin
                m_halt[i] = 0; m_stall[i] = 0; m_fl[i] = 0; m_cnt[i] = 0;
                e_cnt = 0;
            end else begin
                e_cnt = m_cnt[i];
                e_ub  = (k == 2'd0);
                if (m_halt[i] != 0) begin
                    e_st = 3;
                end else if (m_stall[i] != 0) begin
                    e_st = 1;
                    m_stall[i] = 0;
                    if (h) m_halt[i] = 1;
                end else if (m_fl[i] > 0) begin
                    e_st = 2; e_pc = 1; e_fl = 1;
                    if (h) begin m_halt[i] = 1; m_fl[i] = 0; end
                    else m_fl[i]--;
                end else begin
                    if (h) m_halt[i] = 1;
                    else if (lu) m_stall[i] = 1;
                    else if (v && tk) begin
                        e_bt = 1; e_pc = 1;
                        e_fl = DS ? 0 : 1;
                        e_ie = DS ? 1 : 0;
                        if (m_cnt[i] < cmax[i]) m_cnt[i]++;
                        m_fl[i] = DS ? 0 : fcyc[i] - 1;
                    end else begin
                        e_pc = 1; e_ie = 1;
                    end
                end
            end
            chk($sformatf("u%0d_BrTaken", i), 32'(bt[i]), 32'(e_bt));
            chk($sformatf("u%0d_UnCondBr", i), 32'(ub[i]), 32'(e_ub));
            chk($sformatf("u%0d_pc_en", i), 32'(pc[i]), 32'(e_pc));
            if (e_fl == 0) chk($sformatf("u%0d_ifid_en", i), 32'(ie[i]), 32'(e_ie));
            chk($sformatf("u%0d_ifid_flush", i), 32'(fl[i]), 32'(e_fl));
            chk($sformatf("u%0d_state", i), (i == 0) ? 32'(st0) : 32'(st1), 32'(e_st));
            chk($sformatf("u%0d_taken_cnt", i), (i == 0) ? 32'(tc0) : 32'(tc1), 32'(e_cnt));
        end
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) step(1, 0, 2'd3, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 0; br_valid = 0; br_kind = 0; rt_zero = 0;
        flag_n = 0; flag_v = 0; load_use = 0; halt_req = 0;
        for (int i = 0; i < 2; i++) begin
            m_halt[i] = 0; m_stall[i] = 0; m_fl[i] = 0; m_cnt[i] = 0;
        end

        // Reset: everything low even with a B in decode
        step(0, 1, 2'd0, 1, 1, 0, 0, 0);
        step(0, 1, 2'd0, 1, 1, 0, 0, 0);
        chk("rst_pc_en", 32'(pc[0]), 32'd0);
        idle(3);
        chk("run_pc_en", 32'(pc[0]), 32'd1);

        // CBZ taken then not taken
        step(1, 1, 2'd1, 1, 0, 0, 0, 0);
        chk("cbz_taken_flush", 32'(fl[0]), DS ? 32'd0 : 32'd1);
        step(1, 0, 2'd3, 0, 0, 0, 0, 0);
        chk("cbz_next_state", 32'(st0), DS ? 32'd0 : 32'd2);
        chk("cbz_cnt", 32'(tc0), 32'd1);
        idle(3);
        step(1, 1, 2'd1, 0, 0, 0, 0, 0);
        chk("cbz_nt_brtaken", 32'(bt[0]), 32'd0);

        // B.LT and reserved kind
        step(1, 1, 2'd2, 0, 1, 0, 0, 0);
        chk("blt_taken", 32'(bt[0]), 32'd1);
        idle(3);
        step(1, 1, 2'd2, 0, 1, 1, 0, 0);
        chk("blt_nt", 32'(bt[0]), 32'd0);
        step(1, 1, 2'd3, 1, 1, 0, 0, 0);
        chk("rsv_nt", 32'(bt[0]), 32'd0);

        // Load-use stall holding an unconditional branch
        step(1, 1, 2'd0, 0, 0, 0, 1, 0);
        step(1, 1, 2'd0, 0, 0, 0, 0, 0);
        chk("lu_stall_state", 32'(st0), 32'd1);
        step(1, 1, 2'd0, 0, 0, 0, 0, 0);
        chk("lu_resolve_bt", 32'(bt[0]), 32'd1);
        chk("lu_resolve_ub", 32'(ub[0]), 32'd1);

        // Halt raised during flush, held for 20 cycles, then reset
        step(1, 0, 2'd3, 0, 0, 0, 0, 0);
        step(1, 0, 2'd3, 0, 0, 0, 0, 0);
        step(1, 1, 2'd0, 0, 0, 0, 0, 0);
        step(1, 0, 2'd3, 0, 0, 0, 0, 1);
        for (int c = 0; c < 20; c++) begin
            step(1, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 0);
            chk("halt_pc_en", 32'(pc[0]), 32'd0);
        end
        step(0, 0, 2'd3, 0, 0, 0, 0, 0);
        chk("halt_rst_cnt", 32'(tc0), 32'd0);

        // Saturation of the 3-bit counter
        for (int c = 0; c < 11; c++) step(1, 1, 2'd0, 0, 0, 0, 0, 0);
        chk("sat_cnt", 32'(tc1), 32'd7);

        // Randomised run against the model, with occasional reset and halt
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 49) != 0), 1'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
